// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// EX result-source code for loads, FSM states and a register-match helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_BUSY = 1'b1
    } hz_state_e;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [4:0] REG_ZERO       = 5'd0;

    // x0 is hardwired to zero, so it never produces a dependency.
    function automatic logic reg_hit(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID/EX/MEM/WB pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if #(parameter int CNT_W = 16);

    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E;
    logic [4:0]       RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             MultiStartE;
    logic             cnt_clr;

    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE;
    logic             BubbleM;
    logic             BusyE;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiStartE, cnt_clr,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
        input  BubbleM, BusyE, stall_cycles, flush_events
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MultiStartE, cnt_clr,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
        output BubbleM, BusyE, stall_cycles, flush_events
    );

endinterface

// File: rtl/hazard_ctrl_forward_sel.sv
// EX operand forwarding select for one source register; the younger MEM result
// takes precedence over WB.
module hazard_ctrl_forward_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_sel_e   sel
);

    // Priority select MEM > WB > register file
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && reg_hit(rd_m, rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && reg_hit(rd_w, rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use,
// branch and multi-cycle stall/flush generation, plus saturating event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    localparam int MC_CNT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;

    hz_state_e            state_q, state_d;
    logic [MC_CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

    fwd_sel_e             fwd_a_s, fwd_b_s;
    logic                 lw_stall_s;
    logic                 mc_stall_s;
    logic                 stall_f_s, stall_d_s, stall_e_s;
    logic                 flush_d_s, flush_e_s;
    logic                 bubble_m_s, busy_e_s;
    logic [1:0]           fwd_a_out_s, fwd_b_out_s;

    hazard_ctrl_forward_sel u_fwd_a (
        .rs          (hz.Rs1E),
        .rd_m        (hz.RdM),
        .rd_w        (hz.RdW),
        .reg_write_m (hz.RegWriteM),
        .reg_write_w (hz.RegWriteW),
        .sel         (fwd_a_s)
    );

    hazard_ctrl_forward_sel u_fwd_b (
        .rs          (hz.Rs2E),
        .rd_m        (hz.RdM),
        .rd_w        (hz.RdW),
        .reg_write_m (hz.RegWriteM),
        .reg_write_w (hz.RegWriteW),
        .sel         (fwd_b_s)
    );

    assign lw_stall_s = (hz.ResultSrcE == RESULT_SRC_MEM) &&
                        (reg_hit(hz.RdE, hz.Rs1D) || reg_hit(hz.RdE, hz.Rs2D));

    // Multi-cycle occupancy FSM; the start cycle counts as the first of MC_LATENCY
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mc_stall_s = 1'b0;
        case (state_q)
            HZ_IDLE: begin
                if (hz.MultiStartE) begin
                    mc_stall_s = 1'b1;
                    state_d    = HZ_BUSY;
                    cnt_d      = MC_CNT_W'(MC_LATENCY - 2);
                end else begin
                    state_d    = HZ_IDLE;
                end
            end
            HZ_BUSY: begin
                if (cnt_q != {MC_CNT_W{1'b0}}) begin
                    mc_stall_s = 1'b1;
                    cnt_d      = cnt_q - MC_CNT_W'(1);
                end else begin
                    state_d    = HZ_IDLE;
                end
            end
            default: begin
                state_d = HZ_IDLE;
                cnt_d   = {MC_CNT_W{1'b0}};
            end
        endcase
    end

    // Prioritised stall/flush outputs; everything is forced low while reset is held
    always_comb begin
        stall_f_s   = 1'b0;
        stall_d_s   = 1'b0;
        stall_e_s   = 1'b0;
        flush_d_s   = 1'b0;
        flush_e_s   = 1'b0;
        bubble_m_s  = 1'b0;
        busy_e_s    = 1'b0;
        fwd_a_out_s = FWD_RF;
        fwd_b_out_s = FWD_RF;
        if (!rst_n) begin
            busy_e_s    = 1'b0;
        end else begin
            fwd_a_out_s = fwd_a_s;
            fwd_b_out_s = fwd_b_s;
            busy_e_s    = mc_stall_s || (state_q == HZ_BUSY);
            if (mc_stall_s) begin
                stall_f_s  = 1'b1;
                stall_d_s  = 1'b1;
                stall_e_s  = 1'b1;
                bubble_m_s = 1'b1;
            end else if (hz.PCSrcE) begin
                flush_d_s  = 1'b1;
                flush_e_s  = 1'b1;
            end else if (lw_stall_s) begin
                stall_f_s  = 1'b1;
                stall_d_s  = 1'b1;
                flush_e_s  = 1'b1;
            end else begin
                stall_f_s  = 1'b0;
            end
        end
    end

    // Saturating performance counters; a clear beats a same-cycle increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.cnt_clr) begin
            stall_cnt_d = {CNT_W{1'b0}};
            flush_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (stall_f_s && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (hz.PCSrcE && !(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HZ_IDLE;
            cnt_q       <= {MC_CNT_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.ForwardAE    = fwd_a_out_s;
    assign hz.ForwardBE    = fwd_b_out_s;
    assign hz.StallF       = stall_f_s;
    assign hz.StallD       = stall_d_s;
    assign hz.StallE       = stall_e_s;
    assign hz.FlushD       = flush_d_s;
    assign hz.FlushE       = flush_e_s;
    assign hz.BubbleM      = bubble_m_s;
    assign hz.BusyE        = busy_e_s;
    assign hz.stall_cycles = stall_cnt_q;
    assign hz.flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MC_LATENCY = 4, CNT_W = 16).
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.MC_LATENCY(4), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif.slave)
    );

    // {StallF, StallD, StallE, FlushD, FlushE, BubbleM, BusyE}
    logic [6:0] ctl;
    assign ctl = {hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE, hif.BubbleM, hif.BusyE};

    localparam logic [6:0] CTL_NONE = 7'b0000000;
    localparam logic [6:0] CTL_LW   = 7'b1100100;
    localparam logic [6:0] CTL_BR   = 7'b0001100;
    localparam logic [6:0] CTL_MC   = 7'b1110011;
    localparam logic [6:0] CTL_REL  = 7'b0000001;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Multi-cycle branches do not exist, so the bench never drives both together
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(hif.PCSrcE && hif.MultiStartE))
                else $error("FAIL stim_branch_mc: PCSrcE and MultiStartE driven together");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hif.Rs1D = 5'd0; hif.Rs2D = 5'd0; hif.Rs1E = 5'd0; hif.Rs2E = 5'd0;
        hif.RdE = 5'd0; hif.RdM = 5'd0; hif.RdW = 5'd0;
        hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; hif.ResultSrcE = 2'b00;
        hif.PCSrcE = 1'b0; hif.MultiStartE = 1'b0; hif.cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        hif.PCSrcE = 1'b1;
        hif.ResultSrcE = 2'b01; hif.RdE = 5'd3; hif.Rs1D = 5'd3;
        hif.Rs1E = 5'd4; hif.RdM = 5'd4; hif.RegWriteM = 1'b1;
        repeat (2) tick();
        n_checks++; if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL rst_ctl: got %b want %b", ctl, CTL_NONE); end
        n_checks++; if (hif.ForwardAE !== 2'b00) begin n_fail++; $display("FAIL rst_fwda: got %b want 00", hif.ForwardAE); end
        n_checks++; if (hif.stall_cycles !== 16'h0000) begin n_fail++; $display("FAIL rst_stall_cnt: got %h want 0000", hif.stall_cycles); end
        n_checks++; if (hif.flush_events !== 16'h0000) begin n_fail++; $display("FAIL rst_flush_cnt: got %h want 0000", hif.flush_events); end
        idle_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_forwarding();
        idle_inputs();
        hif.Rs1E = 5'd5; hif.Rs2E = 5'd5; hif.RdM = 5'd5; hif.RdW = 5'd5;
        hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
        #1;
        n_checks++; if (hif.ForwardAE !== 2'b10) begin n_fail++; $display("FAIL fwd_mem_a: got %b want 10", hif.ForwardAE); end
        n_checks++; if (hif.ForwardBE !== 2'b10) begin n_fail++; $display("FAIL fwd_mem_b: got %b want 10", hif.ForwardBE); end
        hif.RdM = 5'd0;
        #1;
        n_checks++; if (hif.ForwardAE !== 2'b01) begin n_fail++; $display("FAIL fwd_wb_a: got %b want 01", hif.ForwardAE); end
        hif.RdM = 5'd5; hif.RegWriteM = 1'b0;
        #1;
        n_checks++; if (hif.ForwardBE !== 2'b01) begin n_fail++; $display("FAIL fwd_wb_nowrm_b: got %b want 01", hif.ForwardBE); end
        hif.RegWriteW = 1'b0;
        #1;
        n_checks++; if (hif.ForwardBE !== 2'b00) begin n_fail++; $display("FAIL fwd_nowr_b: got %b want 00", hif.ForwardBE); end
        hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
        hif.Rs1E = 5'd0; hif.RdM = 5'd0; hif.RdW = 5'd0;
        hif.Rs2E = 5'd9;
        #1;
        n_checks++; if (hif.ForwardAE !== 2'b00) begin n_fail++; $display("FAIL fwd_x0_a: got %b want 00", hif.ForwardAE); end
        hif.RdM = 5'd9; hif.RdW = 5'd9;
        #1;
        n_checks++; if ({hif.ForwardAE, hif.ForwardBE} !== 4'b0010) begin n_fail++; $display("FAIL fwd_indep: got %b want 0010", {hif.ForwardAE, hif.ForwardBE}); end
        n_checks++; if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL fwd_ctl: got %b want %b", ctl, CTL_NONE); end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_use();
        hif.cnt_clr = 1'b1;
        tick();
        idle_inputs();
        hif.ResultSrcE = 2'b01; hif.RdE = 5'd0;
        #1;
        n_checks++; if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL lu_x0: got %b want %b", ctl, CTL_NONE); end
        hif.RdE = 5'd7; hif.Rs2D = 5'd7; hif.ResultSrcE = 2'b00;
        #1;
        n_checks++; if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL lu_not_load: got %b want %b", ctl, CTL_NONE); end
        hif.ResultSrcE = 2'b01;
        #1;
        n_checks++; if (ctl !== CTL_LW) begin n_fail++; $display("FAIL lu_ctl: got %b want %b", ctl, CTL_LW); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL lu_after: got %b want %b", ctl, CTL_NONE); end
        n_checks++; if (hif.stall_cycles !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", hif.stall_cycles); end
        n_checks++; if (hif.flush_events !== 16'd0) begin n_fail++; $display("FAIL lu_flush_cnt: got %0d want 0", hif.flush_events); end
    endtask

    task automatic test_branch_flush();
        idle_inputs();
        hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs1D = 5'd7; hif.PCSrcE = 1'b1;
        #1;
        n_checks++; if (ctl !== CTL_BR) begin n_fail++; $display("FAIL br_ctl: got %b want %b", ctl, CTL_BR); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (hif.flush_events !== 16'd1) begin n_fail++; $display("FAIL br_flush_cnt: got %0d want 1", hif.flush_events); end
        n_checks++; if (hif.stall_cycles !== 16'd1) begin n_fail++; $display("FAIL br_stall_cnt: got %0d want 1", hif.stall_cycles); end
    endtask

    task automatic test_multicycle();
        hif.cnt_clr = 1'b1;
        tick();
        idle_inputs();
        hif.MultiStartE = 1'b1;
        hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs1D = 5'd7;
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_checks++; if (ctl !== CTL_MC) begin n_fail++; $display("FAIL mc_cyc%0d: got %b want %b", c, ctl, CTL_MC); end
            tick();
        end
        hif.ResultSrcE = 2'b00; hif.RdE = 5'd0; hif.Rs1D = 5'd0;
        #1;
        n_checks++; if (ctl !== CTL_REL) begin n_fail++; $display("FAIL mc_release: got %b want %b", ctl, CTL_REL); end
        n_checks++; if (hif.stall_cycles !== 16'd3) begin n_fail++; $display("FAIL mc_stall_cnt: got %0d want 3", hif.stall_cycles); end
        tick();
        hif.MultiStartE = 1'b0;
        #1;
        n_checks++; if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL mc_idle: got %b want %b", ctl, CTL_NONE); end
        n_checks++; if (hif.stall_cycles !== 16'd3) begin n_fail++; $display("FAIL mc_stall_cnt_end: got %0d want 3", hif.stall_cycles); end
    endtask

    task automatic test_saturation();
        hif.cnt_clr = 1'b1;
        tick();
        idle_inputs();
        hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs1D = 5'd7;
        repeat (65534) tick();
        n_checks++; if (hif.stall_cycles !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe: got %h want fffe", hif.stall_cycles); end
        tick();
        n_checks++; if (hif.stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff: got %h want ffff", hif.stall_cycles); end
        repeat (2) tick();
        n_checks++; if (hif.stall_cycles !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", hif.stall_cycles); end
        hif.cnt_clr = 1'b1;
        tick();
        n_checks++; if (hif.stall_cycles !== 16'h0000) begin n_fail++; $display("FAIL sat_clr: got %h want 0000", hif.stall_cycles); end
        n_checks++; if (ctl !== CTL_LW) begin n_fail++; $display("FAIL sat_clr_ctl: got %b want %b", ctl, CTL_LW); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_busy();
        idle_inputs();
        hif.MultiStartE = 1'b1;
        #1;
        n_checks++; if (ctl !== CTL_MC) begin n_fail++; $display("FAIL rb_cyc1: got %b want %b", ctl, CTL_MC); end
        tick();
        n_checks++; if (ctl !== CTL_MC) begin n_fail++; $display("FAIL rb_cyc2: got %b want %b", ctl, CTL_MC); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL rb_drop: got %b want %b", ctl, CTL_NONE); end
        n_checks++; if (hif.stall_cycles !== 16'd0) begin n_fail++; $display("FAIL rb_cnt_rst: got %0d want 0", hif.stall_cycles); end
        tick();
        n_checks++; if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL rb_held: got %b want %b", ctl, CTL_NONE); end
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_checks++; if (ctl !== CTL_MC) begin n_fail++; $display("FAIL rb_restart%0d: got %b want %b", c, ctl, CTL_MC); end
            tick();
        end
        n_checks++; if (ctl !== CTL_REL) begin n_fail++; $display("FAIL rb_release: got %b want %b", ctl, CTL_REL); end
        tick();
        hif.MultiStartE = 1'b0;
        #1;
        n_checks++; if (ctl !== CTL_NONE) begin n_fail++; $display("FAIL rb_idle: got %b want %b", ctl, CTL_NONE); end
        n_checks++; if (hif.stall_cycles !== 16'd3) begin n_fail++; $display("FAIL rb_stall_cnt: got %0d want 3", hif.stall_cycles); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_flush();
        test_multicycle();
        test_saturation();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
